// File: rtl/bin_to_bcd_seq_pkg.sv
// Shared definitions for the sequential binary-to-BCD converter:
// digit geometry, blank code, add-3 threshold, FSM state type and
// the bit-counter width helper.
package bin_to_bcd_seq_pkg;

    localparam int         DIGIT_W    = 4;
    localparam logic [3:0] BCD_BLANK  = 4'hF;
    localparam logic [3:0] ADJ_THRESH = 4'd5;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    // Bits needed to hold a down-counter loaded with bin_w.
    function automatic int cnt_width(input int bin_w);
        return $clog2(bin_w + 1);
    endfunction

endpackage

// File: rtl/bin_to_bcd_seq_add3.sv
// Single-digit double-dabble correction: a nibble of 5 or more gets +3
// so that the following left shift carries correctly into the next digit.
module bcd_add3
    import bin_to_bcd_seq_pkg::*;
(
    input  logic [DIGIT_W-1:0] d_in,
    output logic [DIGIT_W-1:0] d_out
);

    // Conditional +3; 4-bit result, carry out is intentionally dropped.
    always_comb begin
        if (d_in >= ADJ_THRESH) begin
            d_out = d_in + 4'd3;
        end else begin
            d_out = d_in;
        end
    end

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3), one bit per clock.
// start/done handshake; bcd_out/overflow only change on the done edge or reset.
// Optional leading-zero blanking enabled by defining BIN2BCD_LZB_EN: zero digits
// above the most significant nonzero digit become 4'hF (units never blanked).
module bin_to_bcd_seq
    import bin_to_bcd_seq_pkg::*;
#(
    parameter int BIN_W  = 8,
    parameter int DIGITS = 3
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic [BIN_W-1:0]          bin_in,
    output logic                      busy,
    output logic                      done,
    output logic [DIGIT_W*DIGITS-1:0] bcd_out,
    output logic                      overflow
);

    localparam int BCD_W = DIGIT_W * DIGITS;
    localparam int CNT_W = cnt_width(BIN_W);

    state_t             state_q,    state_d;
    logic [BIN_W-1:0]   shift_q,    shift_d;
    logic [BCD_W-1:0]   scratch_q,  scratch_d;
    logic               ovf_scr_q,  ovf_scr_d;
    logic [CNT_W-1:0]   cnt_q,      cnt_d;
    logic               busy_q,     busy_d;
    logic               done_q,     done_d;
    logic [BCD_W-1:0]   bcd_q,      bcd_d;
    logic               overflow_q, overflow_d;

    logic [BCD_W-1:0]   adj_s;
    logic [BCD_W-1:0]   shifted_scratch_s;
    logic               carry_out_s;
    logic [BCD_W-1:0]   display_s;
`ifdef BIN2BCD_LZB_EN
    logic               nz_seen_s;
`endif

    // Per-digit add-3 correction applied to the current scratch register.
    for (genvar g = 0; g < DIGITS; g++) begin : g_add3
        bcd_add3 u_add3 (
            .d_in  (scratch_q[g*DIGIT_W +: DIGIT_W]),
            .d_out (adj_s[g*DIGIT_W +: DIGIT_W])
        );
    end

    // Left shift of {scratch, shift}: binary MSB enters the units LSB,
    // the top digit's MSB falls out and feeds the sticky overflow flag.
    assign shifted_scratch_s = {adj_s[BCD_W-2:0], shift_q[BIN_W-1]};
    assign carry_out_s       = adj_s[BCD_W-1];

    // Presentation of the final scratch value (optionally blanking leading zeros).
    always_comb begin
        display_s = shifted_scratch_s;
`ifdef BIN2BCD_LZB_EN
        nz_seen_s = 1'b0;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            if (nz_seen_s || (shifted_scratch_s[i*DIGIT_W +: DIGIT_W] != 4'd0)) begin
                nz_seen_s = 1'b1;
            end else begin
                display_s[i*DIGIT_W +: DIGIT_W] = BCD_BLANK;
            end
        end
`endif
    end

    // Next-state logic for the FSM, datapath registers and registered outputs.
    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        scratch_d  = scratch_q;
        ovf_scr_d  = ovf_scr_q;
        cnt_d      = cnt_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        bcd_d      = bcd_q;
        overflow_d = overflow_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    shift_d   = bin_in;
                    scratch_d = {BCD_W{1'b0}};
                    ovf_scr_d = 1'b0;
                    cnt_d     = CNT_W'(BIN_W);
                    busy_d    = 1'b1;
                    state_d   = SHIFT;
                end else begin
                    busy_d    = 1'b0;
                end
            end
            SHIFT: begin
                scratch_d = shifted_scratch_s;
                shift_d   = {shift_q[BIN_W-2:0], 1'b0};
                ovf_scr_d = ovf_scr_q | carry_out_s;
                cnt_d     = cnt_q - CNT_W'(1'b1);
                if (cnt_q == CNT_W'(1'b1)) begin
                    bcd_d      = display_s;
                    overflow_d = ovf_scr_q | carry_out_s;
                    done_d     = 1'b1;
                    busy_d     = 1'b0;
                    state_d    = IDLE;
                end else begin
                    busy_d     = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State register with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            shift_q    <= {BIN_W{1'b0}};
            scratch_q  <= {BCD_W{1'b0}};
            ovf_scr_q  <= 1'b0;
            cnt_q      <= {CNT_W{1'b0}};
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            bcd_q      <= {BCD_W{1'b0}};
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            scratch_q  <= scratch_d;
            ovf_scr_q  <= ovf_scr_d;
            cnt_q      <= cnt_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            bcd_q      <= bcd_d;
            overflow_q <= overflow_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign bcd_out  = bcd_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Self-checking bench: a 3-digit and a 2-digit converter share stimulus and
// are compared against a decimal reference computed with plain arithmetic.
module tb_bin_to_bcd_seq;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [7:0]  bin_in;
    logic        busy3, done3, ovf3;
    logic [11:0] bcd3;
    logic        busy2, done2, ovf2;
    logic [7:0]  bcd2;

    int n_pass  = 0;
    int n_total = 0;

    bin_to_bcd_seq #(.BIN_W(8), .DIGITS(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .start(start), .bin_in(bin_in),
        .busy(busy3), .done(done3), .bcd_out(bcd3), .overflow(ovf3)
    );

    bin_to_bcd_seq #(.BIN_W(8), .DIGITS(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .start(start), .bin_in(bin_in),
        .busy(busy2), .done(done2), .bcd_out(bcd2), .overflow(ovf2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Decimal reference: value modulo 10^d, one nibble per decimal digit.
    function automatic logic [15:0] ref_bcd(input int v, input int d);
        int m;
        logic [15:0] r;
        m = v % (10 ** d);
        r = 16'h0000;
        for (int i = 0; i < d; i++) r[4*i +: 4] = 4'((m / (10 ** i)) % 10);
`ifdef BIN2BCD_LZB_EN
        for (int i = 1; i < d; i++) if (m < 10 ** i) r[4*i +: 4] = 4'hF;
`endif
        return r;
    endfunction

    function automatic bit digits_ok(input logic [11:0] b, input int d);
        bit ok;
        ok = 1'b1;
        for (int i = 0; i < d; i++) begin
`ifdef BIN2BCD_LZB_EN
            if (b[4*i +: 4] > 4'd9 && b[4*i +: 4] != 4'hF) ok = 1'b0;
`else
            if (b[4*i +: 4] > 4'd9) ok = 1'b0;
`endif
        end
        return ok;
    endfunction

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; bin_in = 8'd0;
        repeat (3) @(negedge clk);
        n_total++;
        if ({busy3, done3, ovf3, bcd3, busy2, done2, ovf2, bcd2} !== 26'd0)
            $display("FAIL reset_hold: got %h/%h exp 0", bcd3, bcd2);
        else n_pass++;
        rst_n = 1'b1;
        @(negedge clk);
        n_total++;
        if ({busy3, done3, ovf3, bcd3, busy2, done2, ovf2, bcd2} !== 26'd0)
            $display("FAIL reset_release: got %h/%h exp 0", bcd3, bcd2);
        else n_pass++;
    endtask

    // One full conversion of v with latency, busy, stability and result checks.
    task automatic do_conv(input logic [7:0] v, input bit jitter, input string tag);
        int k;
        bit stable_ok;
        logic [11:0] prev3;
        logic [7:0]  prev2;
        logic [15:0] e3, e2;
        e3 = ref_bcd(int'(v), 3);
        e2 = ref_bcd(int'(v), 2);
        @(negedge clk);
        prev3 = bcd3; prev2 = bcd2; stable_ok = 1'b1;
        start = 1'b1; bin_in = v;
        @(negedge clk);
        start = 1'b0; bin_in = 8'($urandom);
        k = 0;
        while (done3 !== 1'b1 && k < 20) begin
            if (busy3 !== 1'b1 || busy2 !== 1'b1 || done2 !== 1'b0 ||
                bcd3 !== prev3 || bcd2 !== prev2) stable_ok = 1'b0;
            start  = (jitter && k < 6) ? 1'($urandom_range(0, 1)) : 1'b0;
            bin_in = 8'($urandom);
            @(negedge clk);
            k++;
        end
        start = 1'b0;
        n_total++;
        if (k != 8) $display("FAIL %s latency: got %0d cycles exp 8", tag, k); else n_pass++;
        n_total++;
        if (!stable_ok) $display("FAIL %s busy_hold: busy/bcd not steady exp busy=1 bcd=%h", tag, prev3);
        else n_pass++;
        n_total++;
        if (busy3 !== 1'b0 || done2 !== 1'b1)
            $display("FAIL %s done_edge: got busy=%b done2=%b exp 0 1", tag, busy3, done2);
        else n_pass++;
        n_total++;
        if (bcd3 !== e3[11:0] || ovf3 !== 1'b0)
            $display("FAIL %s bcd3: got %h ovf %b exp %h ovf 0", tag, bcd3, ovf3, e3[11:0]);
        else n_pass++;
        n_total++;
        if (bcd2 !== e2[7:0] || ovf2 !== (int'(v) >= 100))
            $display("FAIL %s bcd2: got %h ovf %b exp %h ovf %b", tag, bcd2, ovf2, e2[7:0], int'(v) >= 100);
        else n_pass++;
        n_total++;
        if (!digits_ok(bcd3, 3) || !digits_ok({4'h0, bcd2}, 2))
            $display("FAIL %s digit_range: got %h/%h exp digits <= 9", tag, bcd3, bcd2);
        else n_pass++;
        @(negedge clk);
        n_total++;
        if (done3 !== 1'b0 || done2 !== 1'b0 || bcd3 !== e3[11:0])
            $display("FAIL %s done_pulse: got done=%b bcd=%h exp 0 %h", tag, done3, bcd3, e3[11:0]);
        else n_pass++;
    endtask

    task automatic test_boundaries();
        do_conv(8'd255, 1'b0, "max255");
        n_total++;
`ifdef BIN2BCD_LZB_EN
        if (bcd3 !== 12'h255) $display("FAIL max255_const: got %h exp 255", bcd3); else n_pass++;
`else
        if (bcd3 !== 12'h255) $display("FAIL max255_const: got %h exp 255", bcd3); else n_pass++;
`endif
        do_conv(8'd0,   1'b0, "zero");
        do_conv(8'd100, 1'b0, "ovf100");
        do_conv(8'd99,  1'b0, "edge99");
    endtask

    task automatic test_back_to_back();
        logic [15:0] e;
        int k;
        @(negedge clk);
        start = 1'b1; bin_in = 8'd42;
        @(negedge clk);
        bin_in = 8'd7;
        k = 0;
        while (done3 !== 1'b1 && k < 20) begin @(negedge clk); k++; end
        e = ref_bcd(42, 3);
        n_total++;
        if (k != 8 || bcd3 !== e[11:0])
            $display("FAIL b2b_first: got %h after %0d exp %h after 8", bcd3, k, e[11:0]);
        else n_pass++;
        @(negedge clk);
        start = 1'b0;
        n_total++;
        if (busy3 !== 1'b1) $display("FAIL b2b_restart: got busy=%b exp 1", busy3); else n_pass++;
        k = 0;
        while (done3 !== 1'b1 && k < 20) begin @(negedge clk); k++; end
        e = ref_bcd(7, 3);
        n_total++;
        if (k != 8 || bcd3 !== e[11:0] || ovf3 !== 1'b0)
            $display("FAIL b2b_second: got %h after %0d exp %h after 8", bcd3, k, e[11:0]);
        else n_pass++;
        @(negedge clk);
    endtask

    task automatic test_async_reset();
        bit quiet;
        @(negedge clk);
        start = 1'b1; bin_in = 8'd200;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_total++;
        if ({busy3, done3, ovf3, bcd3, busy2, done2, ovf2, bcd2} !== 26'd0)
            $display("FAIL async_reset: got busy=%b bcd=%h/%h exp 0", busy3, bcd3, bcd2);
        else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        quiet = 1'b1;
        repeat (12) begin
            @(negedge clk);
            if (done3 !== 1'b0 || busy3 !== 1'b0 || done2 !== 1'b0 || bcd3 !== 12'h000) quiet = 1'b0;
        end
        n_total++;
        if (!quiet) $display("FAIL reset_abort: got activity after reset exp none");
        else n_pass++;
    endtask

    task automatic test_sweep();
        for (int v = 0; v < 256; v++) do_conv(8'(v), 1'b0, "sweep");
    endtask

    task automatic test_random();
        for (int i = 0; i < 30; i++) do_conv(8'($urandom), 1'b1, "random");
    endtask

    initial begin
        test_reset();
        test_boundaries();
        test_back_to_back();
        test_async_reset();
        test_sweep();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/bin_to_bcd_seq.md
Name: bin_to_bcd_seq

Overview:
- Sequential binary-to-BCD converter using the shift-and-add-3 (double-dabble) method, one bit per clock.
- Produces the packed BCD digit vectors that the 7-segment digit decoders consume, one 4-bit nibble per display digit.
- Sits between arithmetic/counter logic and the display decode stage.
- Start/done handshake; the result is held stable between conversions.

Parameters:
- BIN_W, 8, width of the binary input; also the number of shift cycles.
- DIGITS, 3, number of BCD output digits; 10^DIGITS-1 is the largest value representable without overflow.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  reset, asynchronous, active-low; one clock; reset is asynchronous and active-low.
- start  input  1  request a conversion; sampled only while idle (busy=0).
- bin_in  input  BIN_W  unsigned binary value; captured on the accepting edge only.
- busy  output  1  high while a conversion is in progress.
- done  output  1  single-cycle pulse when bcd_out/overflow are updated.
- bcd_out  output  4*DIGITS  packed BCD; digit 0 (units) in bits [3:0].
- overflow  output  1  result exceeded 10^DIGITS-1; bcd_out holds the value modulo 10^DIGITS.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - FSM goes to IDLE.
  - busy=0, done=0, overflow=0, bcd_out=all zeros.
  - Internal shift and scratch registers are cleared.
  - Reset during SHIFT aborts the conversion; no done pulse is produced.
- FSM states: IDLE, SHIFT.
- IDLE:
  - On an edge with start=1: capture bin_in into the shift register, clear the BCD scratch register, clear the overflow scratch flag, load bit counter = BIN_W, set busy=1, go to SHIFT.
  - start=0: remain in IDLE.
- SHIFT, one iteration per edge:
  - Every scratch digit >=5 gets +3 (4-bit add, no carry out).
  - Then {scratch, shift} is shifted left one bit; the binary MSB enters the units-digit LSB.
  - If the bit shifted out of the top digit is 1, set the overflow scratch flag (sticky).
  - Counter decrements.
- Final iteration (counter = 1 before the edge):
  - On that same edge, bcd_out is loaded with the post-shift scratch and overflow with the sticky flag.
  - done=1 for one cycle, busy=0, go to IDLE.
- Latency: start accepted at edge E0; done/bcd_out valid after edge E_BIN_W, i.e. BIN_W cycles later. Throughput is one conversion per BIN_W+1 cycles.
- start while busy=1 is ignored, not queued; bin_in changes while busy have no effect.
- start=1 in the cycle done=1 is accepted, because the FSM is already IDLE.
- bcd_out and overflow change only on the done edge and never expose intermediate values. Reset is the only other event that changes them.
- Each output digit is always in 0..9, except with the optional feature below.
- Zero input: bcd_out=0, overflow=0.
- Maximum input (2^BIN_W-1) with default parameters: 255 gives 0x255, no overflow.

Optional Feature:
- Macro: BIN2BCD_LZB_EN (leading-zero blanking).
- Defined: on the done edge, every zero digit above the most significant nonzero digit is replaced by the blank code 4'hF. The units digit is never blanked, so 0 is shown as a single 0. The downstream segment decoder's default case turns off all segments for 4'hF. overflow is unaffected.
- Not defined: plain BCD, with leading zeros output as 4'h0.

Decomposition:
- Shared package:
  - DIGIT_W=4
  - BCD_BLANK=4'hF
  - ADJ_THRESH=4'd5
  - FSM state enum {IDLE, SHIFT}
  - Helper function for the counter width, clog2(BIN_W+1).
- Sub-module bcd_add3: combinational, 4-bit in/out, adds 3 when the input is >=5. Instantiated DIGITS times by a generate loop.
- The FSM, counter and shift registers stay in bin_to_bcd_seq.

Test Plan:
- Reset then start with bin_in=8'd255 -> busy=1 for 8 cycles; done pulses once on the 8th edge after the start edge; bcd_out=12'h255, overflow=0.
- bin_in=0 -> bcd_out=12'h000, overflow=0. With BIN2BCD_LZB_EN defined, bcd_out=12'hFF0.
- DIGITS=2, BIN_W=8, bin_in=8'd100 -> bcd_out=8'h00, overflow=1. Then bin_in=8'd99 -> bcd_out=8'h99, overflow=0.
- start held high through a conversion of 8'd42 while bin_in changes to 8'd7 mid-conversion -> result 12'h042; a new conversion starts on the done cycle and yields 12'h007 eight cycles later.
- Assert rst_n=0 asynchronously, mid-clock, 3 cycles into a conversion of 8'd200 -> all outputs zero immediately. After release there is no done pulse until a new start.
- Sweep bin_in 0..255 with the default parameters -> each result matches the decimal reference and every digit is <=9.
